ps2_host_tx: RTL

- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) followed by the LED mask, or 0xFF (reset).
- It is the opposite direction of the keyboard receive path, which feeds the key-detection/7-segment logic.
- It drives the shared open-drain ps2c/ps2d lines through output-enable pins only. Pad tristate logic lives at top level.
- `tx_busy` gates the receiver so the receiver ignores device clocks during a host transfer.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_clk_filter.sv | 41 ++++
 rtl/ps2_host_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length and
// keyboard command bytes used by both host transmit and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_REQ,
        ST_START,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_t;

    localparam int FRAME_LEN = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the PS/2 clock line and emits a one-cycle pulse on each
// filtered falling edge; shared by the host transmitter and the receiver.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ps2c_in,
    output logic o_level,
    output logic o_fall
);

    logic [FILTER_LEN-1:0] r_shift;
    logic                  r_level;
    logic                  r_fall;
    logic [FILTER_LEN-1:0] w_next;

    assign w_next = {r_shift[FILTER_LEN-2:0], i_ps2c_in};

    // The idle bus is pulled high, so the filter starts out at level 1.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= '1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_shift <= w_next;
            r_fall  <= 1'b0;
            if (&w_next) begin
                r_level <= 1'b1;
            end else if (~|w_next) begin
                r_level <= 1'b0;
                r_fall  <= r_level;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send,
// then shifts one byte plus odd parity out on device-generated clocks.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr_ps2,
    input  logic [7:0] i_din,
    input  logic       i_ps2c_in,
    input  logic       i_ps2d_in,
    output logic       o_ps2c_oe,
    output logic       o_ps2d_oe,
    output logic       o_tx_busy,
    output logic       o_tx_done_tick,
    output logic       o_tx_ack_err,
    output logic       o_tx_timeout
);

    localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    N_STOP   = 4'(FRAME_LEN - 2);

    ps2_tx_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_n;
    logic [8:0]    r_frame;
    logic          r_ps2c_oe;
    logic          r_ps2d_oe;
    logic          r_busy;
    logic          r_done;
    logic          r_ack_err;
    logic          r_timeout;
    logic [1:0]    r_d_sync;
    logic          w_clk_level;
    logic          w_fall;
    logic          w_ps2d;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_ps2c_in (i_ps2c_in),
        .o_level   (w_clk_level),
        .o_fall    (w_fall)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_d_sync <= 2'b11;
        else         r_d_sync <= {r_d_sync[0], i_ps2d_in};
    end
    assign w_ps2d = r_d_sync[1];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_n       <= '0;
            r_frame   <= '0;
            r_ps2c_oe <= 1'b0;
            r_ps2d_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_wr_ps2) begin
                        r_frame   <= {odd_parity(i_din), i_din};
                        r_busy    <= 1'b1;
                        r_ack_err <= 1'b0;
                        r_ps2c_oe <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_RTS;
                    end
                end
                ST_RTS: begin
                    if (r_cnt == INH_LAST) begin
                        r_ps2d_oe <= 1'b1;
                        r_state   <= ST_REQ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    r_ps2c_oe <= 1'b0;
                    r_cnt     <= '0;
                    r_n       <= '0;
                    r_state   <= ST_START;
                end
                ST_START, ST_DATA, ST_ACK, ST_WAIT_IDLE: begin
                    // Timeout is checked first so it wins over a coincident fall.
                    if (r_cnt == TO_LAST) begin
                        r_ps2c_oe <= 1'b0;
                        r_ps2d_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_state == ST_ACK) begin
                            if (w_fall) begin
                                r_n       <= r_n + 1'b1;
                                r_ack_err <= w_ps2d;
                                r_state   <= ST_WAIT_IDLE;
                            end
                        end else if (r_state == ST_WAIT_IDLE) begin
                            if (w_clk_level && w_ps2d) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end else if (w_fall) begin
                            r_n <= r_n + 1'b1;
                            if (r_n == N_STOP) begin
                                r_ps2d_oe <= 1'b0;
                                r_state   <= ST_ACK;
                            end else begin
                                // Data bits LSB first, then parity, off the shift register.
                                r_ps2d_oe <= ~r_frame[0];
                                r_frame   <= {1'b0, r_frame[8:1]};
                                r_state   <= ST_DATA;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ps2c_oe      = r_ps2c_oe;
    assign o_ps2d_oe      = r_ps2d_oe;
    assign o_tx_busy      = r_busy;
    assign o_tx_done_tick = r_done;
    assign o_tx_ack_err   = r_ack_err;
    assign o_tx_timeout   = r_timeout;

endmodule
